// File: rtl/sat_pkg.sv
// Shared definitions for the saturating lane adder: operation modes and signed range limits.
package sat_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Largest value representable in a w-bit two's-complement word.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a w-bit two's-complement word.
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_add_lane.sv
// One saturating lane: W+1 bit add/sub/accumulate, clip to the W-bit range, result, flag
// and accumulator registers.
module sat_add_lane
  import sat_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_stall,
  input  logic         i_valid,
  input  mode_e        i_mode,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_c,
  output logic         o_sat,
  output logic         o_sat_d
);

  localparam logic [W-1:0] MaxVal = W'(sat_max(W));
  localparam logic [W-1:0] MinVal = W'(sat_min(W));

  logic [W:0]   w_a_ext;
  logic [W:0]   w_b_ext;
  logic [W:0]   w_acc_ext;
  logic [W:0]   w_sum;
  logic [W-1:0] w_res;
  logic         w_sat;
  logic         w_upd;
  logic [W-1:0] r_c;
  logic         r_sat;
  logic [W-1:0] r_acc;

  assign w_a_ext   = {i_a[W-1], i_a};
  assign w_b_ext   = {i_b[W-1], i_b};
  assign w_acc_ext = {r_acc[W-1], r_acc};

  always_comb begin
    w_sum = w_a_ext;
    unique case (i_mode)
      MODE_ADD:  w_sum = w_a_ext + w_b_ext;
      MODE_SUB:  w_sum = w_a_ext - w_b_ext;
      MODE_ACC:  w_sum = w_acc_ext + w_a_ext;
      MODE_LOAD: w_sum = w_a_ext;
    endcase
  end

  // The two top bits of the W+1 result disagree exactly when it left the W-bit range.
  always_comb begin
    w_sat = 1'b0;
    w_res = w_sum[W-1:0];
    if (w_sum[W] != w_sum[W-1]) begin
      w_sat = 1'b1;
      w_res = w_sum[W] ? MinVal : MaxVal;
    end
  end

  assign w_upd = i_valid && !i_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c   <= '0;
      r_sat <= 1'b0;
      r_acc <= '0;
    end else if (w_upd) begin
      r_c   <= w_res;
      r_sat <= w_sat;
      if (i_mode == MODE_ACC || i_mode == MODE_LOAD) begin
        r_acc <= w_res;
      end
    end
  end

  assign o_c     = r_c;
  assign o_sat   = r_sat;
  assign o_sat_d = w_sat && i_valid;

endmodule

// File: rtl/sat_add_lanes.sv
// Multi-lane pipelined saturating add/sub/accumulate for LDPC message arithmetic.
// S1 registers operands and mode; S2 (inside each lane) computes, clips and registers results.
module sat_add_lanes
  import sat_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_in_valid,
  input  logic [1:0]         i_mode,
  input  logic [LANES*W-1:0] i_a,
  input  logic [LANES*W-1:0] i_b,
  output logic               o_out_valid,
  output logic [LANES*W-1:0] o_c,
  output logic [LANES-1:0]   o_sat_flag,
  output logic [CNT_W-1:0]   o_sat_count
);

  logic               r_s1_valid;
  mode_e              r_s1_mode;
  logic [LANES*W-1:0] r_s1_a;
  logic [LANES*W-1:0] r_s1_b;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_sat_count;
  logic [LANES-1:0]   w_sat_d;
  logic               w_cnt_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (!i_stall) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_mode <= mode_e'(i_mode);
        r_s1_a    <= i_a;
        r_s1_b    <= i_b;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_add_lane #(
      .W(W)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_stall (i_stall),
      .i_valid (r_s1_valid),
      .i_mode  (r_s1_mode),
      .i_a     (r_s1_a[g*W +: W]),
      .i_b     (r_s1_b[g*W +: W]),
      .o_c     (o_c[g*W +: W]),
      .o_sat   (o_sat_flag[g]),
      .o_sat_d (w_sat_d[g])
    );
  end

  // Counts the beat being registered now, so the count lines up with the flags it reflects.
  assign w_cnt_inc = !i_stall && r_s1_valid && (|w_sat_d) && (r_sat_count != '1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_sat_count <= '0;
    end else if (!i_stall) begin
      r_out_valid <= r_s1_valid;
      if (w_cnt_inc) begin
        r_sat_count <= r_sat_count + CNT_W'(1);
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_sat_count = r_sat_count;

endmodule

// File: tb/tb_sat_add_lanes.sv
// Bench for sat_add_lanes: directed scenarios plus randomized traffic against an integer model.
module tb_sat_add_lanes;

  localparam int W      = 16;
  localparam int LANES  = 4;
  localparam int CNT_W  = 16;
  localparam int CNT_W2 = 3;
  localparam int MAXV   = 32767;
  localparam int MINV   = -32768;
  localparam int CMAX   = 65535;
  localparam int CMAX2  = 7;

  logic               clk = 1'b0;
  logic               rst, stall, in_valid;
  logic [1:0]         mode;
  logic [LANES*W-1:0] a_in, b_in;
  logic               out_valid, ov2;
  logic [LANES*W-1:0] c_out, c2;
  logic [LANES-1:0]   flag_out, f2;
  logic [CNT_W-1:0]   cnt_out;
  logic [CNT_W2-1:0]  cnt2;

  always #5 clk = ~clk;

  sat_add_lanes #(.W(W), .LANES(LANES), .CNT_W(CNT_W)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_in_valid(in_valid), .i_mode(mode),
    .i_a(a_in), .i_b(b_in), .o_out_valid(out_valid), .o_c(c_out), .o_sat_flag(flag_out),
    .o_sat_count(cnt_out)
  );

  // Narrow counter instance so the sticky maximum is reachable quickly.
  sat_add_lanes #(.W(W), .LANES(LANES), .CNT_W(CNT_W2)) u_dut_small (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_in_valid(in_valid), .i_mode(mode),
    .i_a(a_in), .i_b(b_in), .o_out_valid(ov2), .o_c(c2), .o_sat_flag(f2),
    .o_sat_count(cnt2)
  );

  int vecs  = 0;
  int fails = 0;

  int g_a[LANES];
  int g_b[LANES];

  // Reference model state.
  bit                 s1_v = 0;
  int                 s1_m;
  int                 s1_a[LANES];
  int                 s1_b[LANES];
  int                 m_acc[LANES];
  bit                 m_ov;
  logic [LANES*W-1:0] m_c;
  logic [LANES-1:0]   m_f;
  int                 m_cnt, m_cnt2;

  function automatic int clip(input int s, output bit f);
    f = 1'b0;
    if (s > MAXV) begin f = 1'b1; return MAXV; end
    if (s < MINV) begin f = 1'b1; return MINV; end
    return s;
  endfunction

  task automatic fill(input int x, input int y);
    for (int i = 0; i < LANES; i++) begin g_a[i] = x; g_b[i] = y; end
  endtask

  // Drive one cycle of stimulus, clock it, advance the model, settle before sampling.
  task automatic cyc(input bit r, input bit st, input bit v, input int md);
    int s; bit f; bit anyf;
    rst = r; stall = st; in_valid = v; mode = 2'(md);
    for (int i = 0; i < LANES; i++) begin
      a_in[i*W +: W] = W'(g_a[i]);
      b_in[i*W +: W] = W'(g_b[i]);
    end
    @(posedge clk);
    if (r) begin
      s1_v = 0; m_ov = 0; m_c = '0; m_f = '0; m_cnt = 0; m_cnt2 = 0;
      for (int i = 0; i < LANES; i++) m_acc[i] = 0;
    end else if (!st) begin
      if (s1_v) begin
        anyf = 0;
        for (int i = 0; i < LANES; i++) begin
          case (s1_m)
            0:       s = s1_a[i] + s1_b[i];
            1:       s = s1_a[i] - s1_b[i];
            2:       s = m_acc[i] + s1_a[i];
            default: s = s1_a[i];
          endcase
          s = clip(s, f);
          m_c[i*W +: W] = W'(s);
          m_f[i] = f;
          anyf |= f;
          if (s1_m >= 2) m_acc[i] = s;
        end
        if (anyf) begin
          if (m_cnt < CMAX) m_cnt++;
          if (m_cnt2 < CMAX2) m_cnt2++;
        end
      end
      m_ov = s1_v;
      if (v) begin s1_m = md; s1_a = g_a; s1_b = g_b; end
      s1_v = v;
    end
    #1;
  endtask

  task automatic test_reset();
    fill(1, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 1, 0);
      vecs++;
      if (out_valid !== 1'b0 || c_out !== '0 || cnt_out !== '0 || flag_out !== '0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d got ov=%b c=%h cnt=%0d exp 0", k, out_valid, c_out, cnt_out);
      end
    end
    cyc(0, 0, 1, 0);
    vecs++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_lat1 got ov=%b exp 0", out_valid);
    end
    fill(0, 0);
    cyc(0, 0, 0, 0);
    vecs++;
    if (out_valid !== 1'b1 || c_out !== {LANES{16'd2}}) begin
      fails++; $display("FAIL reset_lat2 got ov=%b c=%h exp ov=1 c=0002x4", out_valid, c_out);
    end
  endtask

  task automatic test_add();
    int ax[6] = '{3, 3, -30, 32000, -2000, -32767};
    int bx[6] = '{-2, 13, -123, 1000, -32500, -1};
    int ex[6] = '{1, 16, -153, 32767, -32768, -32768};
    bit fx[6] = '{0, 0, 0, 1, 1, 0};
    logic [W-1:0] ev;
    for (int k = 0; k < 6; k++) begin
      fill(ax[k], bx[k]); cyc(0, 0, 1, 0);
      fill(0, 0);         cyc(0, 0, 0, 0);
      ev = W'(ex[k]);
      vecs++;
      if (out_valid !== 1'b1 || c_out !== {LANES{ev}} || flag_out !== {LANES{fx[k]}}) begin
        fails++;
        $display("FAIL add_%0d got ov=%b c=%h f=%b exp c=%h f=%b", k, out_valid, c_out, flag_out,
                 {LANES{ev}}, {LANES{fx[k]}});
      end
    end
    vecs++;
    if (cnt_out !== 16'd2) begin
      fails++; $display("FAIL add_count got %0d exp 2", cnt_out);
    end
  endtask

  task automatic test_sub();
    int ax[3] = '{5, 0, -32768};
    int bx[3] = '{7, -32768, 1};
    int ex[3] = '{-2, 32767, -32768};
    bit fx[3] = '{0, 1, 1};
    int el[LANES] = '{32767, -2, -32768, 200};
    logic [W-1:0] ev;
    logic [LANES*W-1:0] evec;
    for (int k = 0; k < 3; k++) begin
      fill(ax[k], bx[k]); cyc(0, 0, 1, 1);
      fill(0, 0);         cyc(0, 0, 0, 0);
      ev = W'(ex[k]);
      vecs++;
      if (out_valid !== 1'b1 || c_out !== {LANES{ev}} || flag_out !== {LANES{fx[k]}}) begin
        fails++;
        $display("FAIL sub_%0d got c=%h f=%b exp c=%h f=%b", k, c_out, flag_out, {LANES{ev}},
                 {LANES{fx[k]}});
      end
    end
    g_a = '{0, 5, -32768, 100};
    g_b = '{-32768, 7, 1, -100};
    cyc(0, 0, 1, 1);
    fill(0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < LANES; i++) evec[i*W +: W] = W'(el[i]);
    vecs++;
    if (c_out !== evec || flag_out !== 4'b0101 || cnt_out !== 16'd5) begin
      fails++;
      $display("FAIL sub_lanes got c=%h f=%b cnt=%0d exp c=%h f=0101 cnt=5", c_out, flag_out,
               cnt_out, evec);
    end
  endtask

  task automatic test_acc();
    int ex[5] = '{30000, 32000, 32767, 32767, 32766};
    bit fx[5] = '{0, 0, 1, 1, 0};
    int av[5] = '{2000, 2000, 2000, -1, 0};
    logic [W-1:0] ev;
    fill(30000, 0); cyc(0, 0, 1, 3);
    for (int k = 0; k < 5; k++) begin
      fill(av[k], 0);
      cyc(0, 0, k < 4, 2);
      ev = W'(ex[k]);
      vecs++;
      if (out_valid !== 1'b1 || c_out !== {LANES{ev}} || flag_out !== {LANES{fx[k]}}) begin
        fails++;
        $display("FAIL acc_%0d got ov=%b c=%h f=%b exp c=%h f=%b", k, out_valid, c_out, flag_out,
                 {LANES{ev}}, {LANES{fx[k]}});
      end
    end
    cyc(0, 0, 0, 0);
    vecs++;
    if (out_valid !== 1'b0 || c_out !== {LANES{16'd32766}} || cnt_out !== 16'd7) begin
      fails++;
      $display("FAIL acc_hold got ov=%b c=%h cnt=%0d exp ov=0 c=7ffe cnt=7", out_valid, c_out,
               cnt_out);
    end
  endtask

  task automatic test_stall();
    int sum = 10;
    logic [LANES*W-1:0] hold_c;
    logic hold_v;
    fill(10, 0); cyc(0, 0, 1, 3);
    for (int k = 0; k < 12; k++) begin
      bit st = (k >= 4 && k < 7);
      int v = int'($urandom_range(0, 200)) - 100;
      fill(v, 0);
      if (k == 4) begin hold_c = c_out; hold_v = out_valid; end
      cyc(0, st, k < 9, 2);
      if (!st && k < 9) sum += v;
      vecs++;
      if (st && (c_out !== hold_c || out_valid !== hold_v)) begin
        fails++;
        $display("FAIL stall_hold k=%0d got ov=%b c=%h exp ov=%b c=%h", k, out_valid, c_out,
                 hold_v, hold_c);
      end else if (out_valid !== m_ov || c_out !== m_c || flag_out !== m_f) begin
        fails++;
        $display("FAIL stall_seq k=%0d got ov=%b c=%h exp ov=%b c=%h", k, out_valid, c_out,
                 m_ov, m_c);
      end
    end
    vecs++;
    if (c_out !== {LANES{W'(sum)}}) begin
      fails++; $display("FAIL stall_sum got %h exp %h", c_out, {LANES{W'(sum)}});
    end
  endtask

  task automatic test_reset_mid();
    fill(100, 0); cyc(0, 0, 1, 3);
    fill(7, 0);   cyc(0, 0, 1, 2);
    cyc(0, 0, 1, 2);
    cyc(1, 1, 1, 2);
    vecs++;
    if (out_valid !== 1'b0 || c_out !== '0 || cnt_out !== '0 || cnt2 !== '0) begin
      fails++;
      $display("FAIL rstmid_clear got ov=%b c=%h cnt=%0d exp all 0", out_valid, c_out, cnt_out);
    end
    fill(5, 0); cyc(0, 0, 1, 2);
    vecs++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_drop got ov=%b exp 0", out_valid);
    end
    fill(0, 0); cyc(0, 0, 0, 0);
    vecs++;
    if (out_valid !== 1'b1 || c_out !== {LANES{16'd5}}) begin
      fails++; $display("FAIL rstmid_acc got ov=%b c=%h exp c=0005x4", out_valid, c_out);
    end
  endtask

  task automatic test_count_stick();
    fill(32767, 32767);
    for (int k = 0; k < 12; k++) cyc(0, 0, 1, 0);
    fill(0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    vecs++;
    if (cnt2 !== 3'd7 || cnt_out !== 16'd12) begin
      fails++; $display("FAIL count_stick got small=%0d wide=%0d exp 7 and 12", cnt2, cnt_out);
    end
  endtask

  task automatic test_random();
    int pick;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < LANES; i++) begin
        pick = int'($urandom_range(0, 7));
        g_a[i] = (pick == 0) ? MAXV : (pick == 1) ? MINV : int'($urandom_range(0, 65535)) - 32768;
        pick = int'($urandom_range(0, 7));
        g_b[i] = (pick == 0) ? MAXV : (pick == 1) ? MINV : int'($urandom_range(0, 65535)) - 32768;
      end
      cyc(0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)));
      vecs++;
      if (out_valid !== m_ov || c_out !== m_c || flag_out !== m_f ||
          cnt_out !== CNT_W'(m_cnt) || cnt2 !== CNT_W2'(m_cnt2) ||
          ov2 !== m_ov || c2 !== m_c || f2 !== m_f) begin
        fails++;
        $display("FAIL random k=%0d got ov=%b c=%h f=%b cnt=%0d/%0d exp ov=%b c=%h f=%b cnt=%0d/%0d",
                 k, out_valid, c_out, flag_out, cnt_out, cnt2, m_ov, m_c, m_f, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; in_valid = 1'b0; mode = 2'b00; a_in = '0; b_in = '0;
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_stall();
    test_reset_mid();
    test_count_stick();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
